// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RISC core
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] op_code,
   input  logic [4:0] fun_code,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_op,
   output logic       reg_we,
   output logic       reg_dst,
   output logic       wb_sel,
   output logic       busy,
   output logic       halted,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_BRANCH = 3'd6,
      S_HALT   = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      C_R    = 4'd0,
      C_IMM  = 4'd1,
      C_LD   = 4'd2,
      C_ST   = 4'd3,
      C_J    = 4'd4,
      C_BZ   = 4'd5,
      C_BNZ  = 4'd6,
      C_HALT = 4'd7,
      C_ILL  = 4'd8
   } class_e;

   function automatic class_e classify(input logic [5:0] op);
      case (op)
         6'b000000:            return C_R;
         6'b001000, 6'b001001: return C_IMM;
         6'b010000:            return C_LD;
         6'b010001:            return C_ST;
         6'b100000:            return C_J;
         6'b100001:            return C_BZ;
         6'b100010:            return C_BNZ;
         6'b111111:            return C_HALT;
         default:              return C_ILL;
      endcase
   endfunction

   state_e     state_q, state_d;
   logic [5:0] op_q;
   logic [3:0] fun_q;
   logic       err_q, err_d;
   class_e     cls_live, cls_lat;
   logic [3:0] alu_lat;
   logic       unused_fun;

   assign unused_fun = fun_code[4];
   assign cls_live   = classify(op_code);
   assign cls_lat    = classify(op_q);

   // ALU code of the instruction in flight, taken only from the latched fields
   always_comb begin
      alu_lat = 4'b0000;
      case (cls_lat)
         C_R:        alu_lat = fun_q;
         C_IMM:      alu_lat = op_q[0] ? 4'b0101 : 4'b0001;
         C_LD, C_ST: alu_lat = 4'b0001;
         default:    alu_lat = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 6'd0;
         fun_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (state_q == S_DECODE) begin
            op_q  <= op_code;
            fun_q <= fun_code[3:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = 4'b0000;
      reg_we    = 1'b0;
      reg_dst   = 1'b0;
      wb_sel    = 1'b0;
      busy      = 1'b1;
      halted    = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (cls_live)
               C_R, C_IMM, C_LD, C_ST: state_d = S_EXEC;
               C_J, C_BZ, C_BNZ:       state_d = S_BRANCH;
               C_HALT:                 state_d = S_HALT;
               default: begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = (cls_lat == C_R) ? 2'b00 : 2'b10;
            alu_op    = alu_lat;
            state_d   = (cls_lat == C_LD || cls_lat == C_ST) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (cls_lat == C_ST);
            alu_op  = alu_lat;
            if (mem_ready) state_d = (cls_lat == C_LD) ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_we  = 1'b1;
            reg_dst = (cls_lat == C_R);
            wb_sel  = (cls_lat == C_LD);
            alu_op  = alu_lat;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            state_d   = S_FETCH;
            case (cls_lat)
               C_J: begin
                  pc_we  = 1'b1;
                  pc_src = 2'b10;
               end
               C_BZ: begin
                  pc_we  = zero;
                  pc_src = 2'b01;
               end
               C_BNZ: begin
                  pc_we  = ~zero;
                  pc_src = 2'b01;
               end
               default: pc_we = 1'b0;
            endcase
         end
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst, start, zero, mem_ready;
   logic [5:0] op_code;
   logic [4:0] fun_code;
   logic       mem_req, mem_we, iord, ir_we, pc_we, alu_src_a;
   logic       reg_we, reg_dst, wb_sel, busy, halted, err;
   logic [1:0] pc_src, alu_src_b;
   logic [3:0] alu_op;
   logic [19:0] obs;
   int n_tests = 0;
   int n_fail  = 0;

   multicycle_control dut (
      .clk(clk), .rst(rst), .start(start), .op_code(op_code), .fun_code(fun_code),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .busy(busy),
      .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_we, reg_dst, wb_sel, busy, halted, err};

   function automatic logic [19:0] o(input logic mrq, mwe, io, irw, pcw,
                                     input logic [1:0] psrc, input logic asa,
                                     input logic [1:0] asb, input logic [3:0] aop,
                                     input logic rwe, rdst, wsel, bsy, hlt, er);
      return {mrq, mwe, io, irw, pcw, psrc, asa, asb, aop, rwe, rdst, wsel, bsy, hlt, er};
   endfunction

   task automatic chk(input string tag, input logic [19:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
      end
   endtask

   // Inputs are set just after a rising edge; outputs are checked 1 ns later.
   task automatic step(input string tag, input logic [19:0] exp);
      #1;
      chk(tag, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_decode(input logic [5:0] op);
      op_code   = op;
      mem_ready = 1'b1;
      step("fetch_ready", o(1,0,0,1,1,2'b00,0,2'b01,4'h0,0,0,0,1,0,0));
      mem_ready = 1'b0;
      step("decode", o(0,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0,1,0,0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; zero = 1'b0; mem_ready = 1'b0;
      op_code = 6'd0; fun_code = 5'd0;
      #2 chk("reset_outputs", 20'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      step("idle", 20'h0);

      start = 1'b1;
      step("idle_start", 20'h0);
      start = 1'b0;
      step("fetch_wait", o(1,0,0,0,0,2'b00,0,2'b01,4'h0,0,0,0,1,0,0));
      fun_code = 5'b00110;
      fetch_decode(6'b000000);
      op_code = 6'b010000;
      step("exec_rtype", o(0,0,0,0,0,2'b00,1,2'b00,4'h6,0,0,0,1,0,0));
      step("wb_rtype",   o(0,0,0,0,0,2'b00,0,2'b00,4'h6,1,1,0,1,0,0));

      fetch_decode(6'b010000);
      step("exec_load", o(0,0,0,0,0,2'b00,1,2'b10,4'h1,0,0,0,1,0,0));
      for (int i = 0; i < 3; i++)
         step("mem_load_wait", o(1,0,1,0,0,2'b00,0,2'b00,4'h1,0,0,0,1,0,0));
      mem_ready = 1'b1;
      step("mem_load_ready", o(1,0,1,0,0,2'b00,0,2'b00,4'h1,0,0,0,1,0,0));
      mem_ready = 1'b0;
      step("wb_load", o(0,0,0,0,0,2'b00,0,2'b00,4'h1,1,0,1,1,0,0));

      fetch_decode(6'b010001);
      step("exec_store", o(0,0,0,0,0,2'b00,1,2'b10,4'h1,0,0,0,1,0,0));
      mem_ready = 1'b1;
      step("mem_store", o(1,1,1,0,0,2'b00,0,2'b00,4'h1,0,0,0,1,0,0));
      mem_ready = 1'b0;
      step("fetch_after_store", o(1,0,0,0,0,2'b00,0,2'b01,4'h0,0,0,0,1,0,0));

      fetch_decode(6'b100001);
      zero = 1'b1;
      step("beq_taken", o(0,0,0,0,1,2'b01,1,2'b00,4'h0,0,0,0,1,0,0));
      fetch_decode(6'b100001);
      zero = 1'b0;
      step("beq_not_taken", o(0,0,0,0,0,2'b01,1,2'b00,4'h0,0,0,0,1,0,0));
      fetch_decode(6'b100010);
      step("bne_taken", o(0,0,0,0,1,2'b01,1,2'b00,4'h0,0,0,0,1,0,0));
      fetch_decode(6'b100000);
      step("jump", o(0,0,0,0,1,2'b10,1,2'b00,4'h0,0,0,0,1,0,0));

      fetch_decode(6'b001001);
      step("exec_imm", o(0,0,0,0,0,2'b00,1,2'b10,4'h5,0,0,0,1,0,0));
      step("wb_imm",   o(0,0,0,0,0,2'b00,0,2'b00,4'h5,1,0,0,1,0,0));

      fetch_decode(6'b000111);
      start = 1'b1;
      step("halt_illegal", o(0,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,1,1));
      step("halt_hold",    o(0,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,1,1));
      rst = 1'b1;
      #1 chk("reset_clears_err", 20'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      step("idle_after_rst", o(0,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,0,0));
      start = 1'b0;
      fetch_decode(6'b111111);
      step("halt_opcode", o(0,0,0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,1,0));

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b1;
      step("idle_restart", 20'h0);
      start = 1'b0;
      step("fetch_wait2", o(1,0,0,0,0,2'b00,0,2'b01,4'h0,0,0,0,1,0,0));
      #2 rst = 1'b1;
      #1 chk("rst_mid_fetch", 20'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      step("idle_ignores_ready", 20'h0);
      step("idle_stays", 20'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
